// File: rtl/ecp5_pll_pkg.sv
// ecp5_pll_pkg: shared types and constants for the ECP5 EHXPLLL dynamic
// phase-shift controller.
//   state_t      controller state encoding
//   SEL_*        PHASESEL encodings for the four PLL outputs
//   DIR_LAG/LEAD PHASEDIR encodings
//   max_u        helper used to size the shared duration timer
// Optional feature macro: ECP5_PLL_PHASE_LOCK_WAIT_EN adds the StLockWait state.
package ecp5_pll_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StDone
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
        ,
        StLockWait
`endif
    } state_t;

    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    localparam logic DIR_LAG  = 1'b1;
    localparam logic DIR_LEAD = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_ctrl_timer.sv
// phase_ctrl_timer: loadable down-counter with a zero flag. One instance times
// every fixed-length controller state.
//   clk       fabric clock
//   rst       synchronous reset, active-high (clears the count)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load; a state lasting D cycles loads D-1
//   zero      count has reached zero; the counter stops there
module phase_ctrl_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ecp5_pll_phase_ctrl.sv
// ecp5_pll_phase_ctrl: dynamic phase-shift controller for the ECP5 EHXPLLL.
// Turns a valid/ready step request into PHASESEL/PHASEDIR setup followed by a
// train of PHASESTEP low pulses.
//   clk, rst          fabric clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only in idle
//   req_sel/dir/steps target output, direction (1 = lag), number of steps
//   busy              not idle
//   done / err        one-cycle completion / lock-timeout abort pulses
//   steps_done        pulses issued for the current/last request
//   locked            PLL LOCK (only used with the lock-wait feature)
//   phasesel/dir/step/loadreg  to the EHXPLLL dynamic phase inputs
// Optional feature macro: ECP5_PLL_PHASE_LOCK_WAIT_EN waits for locked before
// each step and aborts with err after LOCK_TO cycles without lock.
module ecp5_pll_phase_ctrl
    import ecp5_pll_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned LOCK_TO   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] steps_done,
    input  logic             locked,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             phaseloadreg
);

    localparam int unsigned MAX_DUR = max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(GAP_CYC, LOCK_TO));
    localparam int unsigned TW      = $clog2(MAX_DUR + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] LOCK_LD  = TW'(LOCK_TO - 1);

    state_t           state;
    logic [CNT_W-1:0] steps_q;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic             last_step;

    assign phaseloadreg = 1'b1;
    assign last_step    = (steps_done == steps_q);

`ifndef ECP5_PLL_PHASE_LOCK_WAIT_EN
    logic unused_locked;
    logic unused_lock_ld;
    assign unused_locked  = locked;
    assign unused_lock_ld = ^LOCK_LD;
`endif

    phase_ctrl_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Timer reload mirrors the state transitions below: it loads on the same
    // edge that enters a timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            StIdle: begin
                if (req_valid && (req_steps != '0)) begin
                    tmr_load = 1'b1;
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
                    tmr_val  = LOCK_LD;
`else
                    tmr_val  = SETUP_LD;
`endif
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            StPulse: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            StGap: begin
                if (tmr_zero && !last_step) begin
                    tmr_load = 1'b1;
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
                    tmr_val  = LOCK_LD;
`else
                    tmr_val  = PULSE_LD;
`endif
                end
            end
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
            StLockWait: begin
                if (locked) begin
                    tmr_load = 1'b1;
                    tmr_val  = (steps_done == '0) ? SETUP_LD : PULSE_LD;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            steps_q    <= '0;
            steps_done <= '0;
            phasesel   <= SEL_CLKOS;
            phasedir   <= DIR_LAG;
            phasestep  <= 1'b1;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        phasesel   <= req_sel;
                        phasedir   <= req_dir;
                        steps_q    <= req_steps;
                        steps_done <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (req_steps == '0) begin
                            state <= StDone;
                        end else begin
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
                            state <= StLockWait;
`else
                            state <= StSetup;
`endif
                        end
                    end
                end
                StSetup: begin
                    if (tmr_zero) begin
                        state      <= StPulse;
                        phasestep  <= 1'b0;
                        steps_done <= steps_done + 1'b1;
                    end
                end
                StPulse: begin
                    if (tmr_zero) begin
                        state     <= StGap;
                        phasestep <= 1'b1;
                    end
                end
                StGap: begin
                    if (tmr_zero) begin
                        if (last_step) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
                            state      <= StLockWait;
`else
                            state      <= StPulse;
                            phasestep  <= 1'b0;
                            steps_done <= steps_done + 1'b1;
`endif
                        end
                    end
                end
                StDone: begin
                    // A zero-step request enters here with done low and spends
                    // one extra cycle so done follows acceptance by one cycle.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        state     <= StIdle;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
                StLockWait: begin
                    if (locked) begin
                        if (steps_done == '0) begin
                            state <= StSetup;
                        end else begin
                            state      <= StPulse;
                            phasestep  <= 1'b0;
                            steps_done <= steps_done + 1'b1;
                        end
                    end else if (tmr_zero) begin
                        state     <= StIdle;
                        err       <= 1'b1;
                        phasestep <= 1'b1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ecp5_pll_phase_ctrl.sv
// tb_ecp5_pll_phase_ctrl: directed self-checking bench for ecp5_pll_phase_ctrl.
// Lock-wait scenarios are included when ECP5_PLL_PHASE_LOCK_WAIT_EN is defined.
module tb_ecp5_pll_phase_ctrl;

    localparam int SETUP = 4;
    localparam int PULSE = 4;
    localparam int GAP   = 8;
    localparam int PER   = PULSE + GAP;
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
    localparam int LW = 1;    // extra StLockWait cycle per step when locked is high
`else
    localparam int LW = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel = 2'b00;
    logic       req_dir = 1'b1;
    logic [7:0] req_steps = 8'd0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] steps_done;
    logic       locked = (LW != 0);
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;

    int vectors = 0;
    int miscompares = 0;

    // {phasesel, phasedir, phasestep, phaseloadreg, req_ready, busy, done, err}
    localparam logic [8:0] RST_VEC = 9'b00_1_1_1_1_0_0_0;

    always #5 clk = ~clk;

    ecp5_pll_phase_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .steps_done   (steps_done),
        .locked       (locked),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fall_off(input int j);
        return SETUP + j * PER + (j + 1) * LW;
    endfunction

    function automatic int done_off(input int n);
        return SETUP + n * PER + n * LW;
    endfunction

    task automatic test_reset();
        logic [8:0] obs;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        obs = {phasesel, phasedir, phasestep, phaseloadreg, req_ready, busy, done, err};
        vectors++;
        if (obs !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, want %b", obs, RST_VEC);
        end
        vectors++;
        if (steps_done !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_steps_done: got %0d, want 0", steps_done);
        end
        for (int i = 0; i < 5; i++) step();
        obs = {phasesel, phasedir, phasestep, phaseloadreg, req_ready, busy, done, err};
        vectors++;
        if (obs !== RST_VEC) begin
            miscompares++;
            $display("FAIL idle_outputs: got %b, want %b", obs, RST_VEC);
        end
    endtask

    task automatic test_three_steps();
        int   falls[$];
        int   dones[$];
        logic prev;
        int   dn;
        dn = done_off(3);
        req_sel = 2'b01;
        req_dir = 1'b0;
        req_steps = 8'd3;
        req_valid = 1'b1;
        step();    // edge k
        req_valid = 1'b0;
        vectors++;
        if ({phasesel, phasedir} !== 3'b01_0) begin
            miscompares++;
            $display("FAIL three_sel_dir: got sel=%b dir=%b, want 01 0", phasesel, phasedir);
        end
        vectors++;
        if ({busy, req_ready, phasestep} !== 3'b1_0_1) begin
            miscompares++;
            $display("FAIL three_accept: got busy=%b ready=%b step=%b, want 1 0 1",
                     busy, req_ready, phasestep);
        end
        prev = phasestep;
        for (int i = 1; i <= dn + 2; i++) begin
            step();
            if (prev && !phasestep) falls.push_back(i);
            if (done) dones.push_back(i);
            if (i == dn + 1) begin
                vectors++;
                if ({req_ready, busy} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL three_ready_after_done: got ready=%b busy=%b, want 1 0",
                             req_ready, busy);
                end
            end
            prev = phasestep;
        end
        vectors++;
        if (falls.size() !== 3) begin
            miscompares++;
            $display("FAIL three_fall_count: got %0d, want 3", falls.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                vectors++;
                if (falls[j] !== fall_off(j)) begin
                    miscompares++;
                    $display("FAIL three_fall_%0d: got k+%0d, want k+%0d", j, falls[j], fall_off(j));
                end
            end
        end
        vectors++;
        if (dones.size() !== 1 || dones[0] !== dn) begin
            miscompares++;
            $display("FAIL three_done: got %0d pulses first at k+%0d, want 1 at k+%0d",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1, dn);
        end
        vectors++;
        if (steps_done !== 8'd3 || {phasesel, phasedir} !== 3'b01_0) begin
            miscompares++;
            $display("FAIL three_final: got steps_done=%0d sel=%b dir=%b, want 3 01 0",
                     steps_done, phasesel, phasedir);
        end
    endtask

    task automatic test_zero_steps();
        int dones[$];
        int lows;
        lows = 0;
        req_sel = 2'b10;
        req_dir = 1'b1;
        req_steps = 8'd0;
        req_valid = 1'b1;
        step();    // edge k
        req_valid = 1'b0;
        vectors++;
        if ({busy, phasesel, phasedir, steps_done} !== {1'b1, 2'b10, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL zero_accept: got busy=%b sel=%b dir=%b sd=%0d, want 1 10 1 0",
                     busy, phasesel, phasedir, steps_done);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            if (done) dones.push_back(i);
            if (!phasestep) lows++;
            if (i == 2) begin
                vectors++;
                if ({req_ready, busy} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL zero_ready: got ready=%b busy=%b at k+2, want 1 0",
                             req_ready, busy);
                end
            end
        end
        vectors++;
        if (dones.size() !== 1 || dones[0] !== 1) begin
            miscompares++;
            $display("FAIL zero_done: got %0d pulses first at k+%0d, want 1 at k+1",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
        vectors++;
        if (lows !== 0 || steps_done !== 8'd0) begin
            miscompares++;
            $display("FAIL zero_no_pulse: got %0d low cycles sd=%0d, want 0 0", lows, steps_done);
        end
    endtask

    task automatic test_back_to_back();
        int   rises[$];
        int   dones[$];
        logic prev;
        int   dn;
        dn = done_off(2);
        req_sel = 2'b11;
        req_dir = 1'b1;
        req_steps = 8'd2;
        req_valid = 1'b1;
        step();    // edge k, valid stays high
        prev = busy;
        for (int i = 1; i <= dn + 2; i++) begin
            step();
            if (!prev && busy) rises.push_back(i);
            if (done) dones.push_back(i);
            prev = busy;
        end
        req_valid = 1'b0;
        vectors++;
        if (dones.size() !== 1 || dones[0] !== dn) begin
            miscompares++;
            $display("FAIL b2b_done: got %0d pulses first at k+%0d, want 1 at k+%0d",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1, dn);
        end
        vectors++;
        if (rises.size() !== 1 || rises[0] !== dn + 2) begin
            miscompares++;
            $display("FAIL b2b_reaccept: got %0d acceptances first at k+%0d, want 1 at k+%0d",
                     rises.size(), (rises.size() > 0) ? rises[0] : -1, dn + 2);
        end
        vectors++;
        if (steps_done !== 8'd0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_start: got sd=%0d ready=%b, want 0 0", steps_done, req_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        int         lows;
        int         dones;
        lows = 0;
        dones = 0;
        req_sel = 2'b01;
        req_dir = 1'b0;
        req_steps = 8'd5;
        req_valid = 1'b1;
        step();    // edge k
        req_valid = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        vectors++;
        if (steps_done !== 8'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_progress: got sd=%0d busy=%b at k+9, want 1 1", steps_done, busy);
        end
        rst = 1'b1;
        step();    // edge k+10
        rst = 1'b0;
        obs = {phasesel, phasedir, phasestep, phaseloadreg, req_ready, busy, done, err};
        vectors++;
        if (obs !== RST_VEC || steps_done !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b sd=%0d, want %b sd=0", obs, steps_done, RST_VEC);
        end
        for (int i = 0; i < 70; i++) begin
            step();
            if (done) dones++;
            if (!phasestep) lows++;
        end
        vectors++;
        if (dones !== 0 || lows !== 0 || steps_done !== 8'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after: got done=%0d low=%0d sd=%0d busy=%b, want 0 0 0 0",
                     dones, lows, steps_done, busy);
        end
    endtask

`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
    task automatic test_lock_timeout();
        int errs[$];
        int lows;
        int dones;
        lows = 0;
        dones = 0;
        locked = 1'b0;
        req_sel = 2'b00;
        req_dir = 1'b1;
        req_steps = 8'd2;
        req_valid = 1'b1;
        step();    // edge k
        req_valid = 1'b0;
        for (int i = 1; i <= 1030; i++) begin
            step();
            if (err) errs.push_back(i);
            if (done) dones++;
            if (!phasestep) lows++;
            if (i == 1025) begin
                vectors++;
                if ({req_ready, busy} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL lock_to_idle: got ready=%b busy=%b, want 1 0", req_ready, busy);
                end
            end
        end
        vectors++;
        if (errs.size() !== 1 || errs[0] !== 1024) begin
            miscompares++;
            $display("FAIL lock_to_err: got %0d pulses first at k+%0d, want 1 at k+1024",
                     errs.size(), (errs.size() > 0) ? errs[0] : -1);
        end
        vectors++;
        if (lows !== 0 || dones !== 0) begin
            miscompares++;
            $display("FAIL lock_to_quiet: got low=%0d done=%0d, want 0 0", lows, dones);
        end
    endtask

    task automatic test_lock_late();
        int   falls[$];
        int   dones[$];
        int   errs;
        logic prev;
        errs = 0;
        locked = 1'b0;
        req_steps = 8'd1;
        req_valid = 1'b1;
        step();    // edge k
        req_valid = 1'b0;
        prev = phasestep;
        for (int i = 1; i <= 70; i++) begin
            if (i == 50) locked = 1'b1;    // sampled at edge k+50
            step();
            if (prev && !phasestep) falls.push_back(i);
            if (done) dones.push_back(i);
            if (err) errs++;
            prev = phasestep;
        end
        vectors++;
        if (falls.size() !== 1 || falls[0] !== 54) begin
            miscompares++;
            $display("FAIL lock_late_fall: got %0d falls first at k+%0d, want 1 at k+54",
                     falls.size(), (falls.size() > 0) ? falls[0] : -1);
        end
        vectors++;
        if (dones.size() !== 1 || dones[0] !== 66 || errs !== 0) begin
            miscompares++;
            $display("FAIL lock_late_done: got %0d done first at k+%0d err=%0d, want 1 at k+66 0",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1, errs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_three_steps();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid();
`ifdef ECP5_PLL_PHASE_LOCK_WAIT_EN
        test_lock_timeout();
        test_lock_late();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
